// File: rtl/alu32_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational alu32 between two requesters.
// Each operation takes a fixed IDLE -> EXEC -> DONE path; result and err are registered.
module alu32_arbiter #(
    parameter logic [3:0] OP_MAX = 4'b0111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [3:0]  op0,
    output logic        gnt0,
    output logic        done0,
    input  logic        req1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic [3:0]  op1,
    output logic        gnt1,
    output logic        done1,
    output logic [63:0] result,
    output logic        err,
    output logic        busy,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [63:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_d;
    logic        prio, prio_d;
    logic        owner, owner_d;
    logic        win;
    logic        gnt0_d, gnt1_d, done0_d, done1_d;
    logic [31:0] alu_a_d, alu_b_d;
    logic [3:0]  alu_op_d;
    logic [63:0] result_d;
    logic        err_d;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_MAX;
    endfunction

    // With only one request the priority pointer is irrelevant.
    assign win  = (req0 && req1) ? prio : req1;
    assign busy = (state != IDLE);

    always_comb begin
        state_d  = state;
        prio_d   = prio;
        owner_d  = owner;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        alu_a_d  = alu_a;
        alu_b_d  = alu_b;
        alu_op_d = alu_op;
        result_d = result;
        err_d    = err;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_d  = EXEC;
                    owner_d  = win;
                    gnt0_d   = ~win;
                    gnt1_d   = win;
                    alu_a_d  = win ? a1 : a0;
                    alu_b_d  = win ? b1 : b0;
                    alu_op_d = win ? op1 : op0;
                end
            end
            EXEC: begin
                state_d = DONE;
                if (op_legal(alu_op)) begin
                    result_d = alu_result;
                    err_d    = 1'b0;
                end else begin
                    result_d = '0;
                    err_d    = 1'b1;
                end
                done0_d = ~owner;
                done1_d = owner;
            end
            DONE: begin
                state_d = IDLE;
                prio_d  = ~owner;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset clears data registers too so every output reads 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            prio   <= 1'b0;
            owner  <= 1'b0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_d;
            prio   <= prio_d;
            owner  <= owner_d;
            gnt0   <= gnt0_d;
            gnt1   <= gnt1_d;
            done0  <= done0_d;
            done1  <= done1_d;
            alu_a  <= alu_a_d;
            alu_b  <= alu_b_d;
            alu_op <= alu_op_d;
            result <= result_d;
            err    <= err_d;
        end
    end

endmodule

// File: tb/tb_alu32_arbiter.sv
// Randomized and directed bench for alu32_arbiter with a transaction-level reference model
// and a behavioural stand-in for the combinational alu32.
module tb_alu32_arbiter;

    localparam logic [3:0] OP_MAX = 4'b0111;

    logic        clk, reset;
    logic        req0, req1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  op0, op1;
    logic        gnt0, gnt1, done0, done1, err, busy;
    logic [63:0] result, alu_result;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;

    int n_vec = 0;
    int n_err = 0;

    alu32_arbiter #(.OP_MAX(OP_MAX)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1), .gnt1(gnt1), .done1(done1),
        .result(result), .err(err), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Opcodes above SUB produce junk so that discarding it is observable.
    function automatic logic [63:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        case (op)
            4'd0: return {32'h0, ~a};
            4'd1: return {32'h0, ~b};
            4'd2: return {32'h0, a & b};
            4'd3: return {32'h0, a | b};
            4'd4: return {32'h0, a ^ b};
            4'd5: return {32'h0, ~(a ^ b)};
            4'd6: return {32'h0, a} + {32'h0, b};
            4'd7: return {32'h0, a} - {32'h0, b};
            default: return 64'hDEAD_BEEF_CAFE_F00D;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    // Reference model: remaining cycles of the current operation plus expected outputs.
    int          m_left;
    logic        m_prio, m_owner;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    logic [63:0] m_res;
    logic        m_err, m_gnt0, m_gnt1, m_done0, m_done1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_edge();
        m_gnt0 = 0; m_gnt1 = 0; m_done0 = 0; m_done1 = 0;
        if (reset) begin
            m_left = 0; m_prio = 0; m_owner = 0;
            m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_err = 0;
        end else if (m_left == 0) begin
            if (req0 || req1) begin
                m_owner = (req0 && req1) ? m_prio : req1;
                m_a  = m_owner ? a1 : a0;
                m_b  = m_owner ? b1 : b0;
                m_op = m_owner ? op1 : op0;
                if (m_owner) m_gnt1 = 1; else m_gnt0 = 1;
                m_left = 2;
            end
        end else if (m_left == 2) begin
            m_err = (m_op > OP_MAX);
            m_res = m_err ? 64'h0 : alu_model(m_a, m_b, m_op);
            if (m_owner) m_done1 = 1; else m_done0 = 1;
            m_left = 1;
        end else begin
            m_prio = ~m_owner;
            m_left = 0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("gnt0", 64'(gnt0), 64'(m_gnt0));
        chk("gnt1", 64'(gnt1), 64'(m_gnt1));
        chk("done0", 64'(done0), 64'(m_done0));
        chk("done1", 64'(done1), 64'(m_done1));
        chk("busy", 64'(busy), 64'(m_left != 0));
        chk("alu_a", 64'(alu_a), 64'(m_a));
        chk("alu_b", 64'(alu_b), 64'(m_b));
        chk("alu_op", 64'(alu_op), 64'(m_op));
        chk("result", result, m_res);
        chk("err", 64'(err), 64'(m_err));
    endtask

    task automatic do_reset(input int cycles);
        reset = 1;
        for (int i = 0; i < cycles; i++) step();
        reset = 0;
    endtask

    int   grant_q[$];
    int   done_t[$];
    int   cyc;

    initial begin
        reset = 1; req0 = 1; req1 = 0;
        a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;

        // Reset with req0 held: no grant, everything zero.
        do_reset(2);
        chk("rst_gnt0", 64'(gnt0), 64'h0);
        chk("rst_result", result, 64'h0);
        req0 = 0;
        step();

        // Single AND from requester 0.
        req0 = 1; a0 = 32'h0A0B_1100; b0 = 32'h1010_AB00; op0 = 4'd2;
        step();
        chk("and_gnt0", 64'(gnt0), 64'h1);
        req0 = 0;
        step();
        chk("and_done0", 64'(done0), 64'h1);
        chk("and_res", 64'(result[31:0]), 64'h0000_0100);
        chk("and_err", 64'(err), 64'h0);
        step();

        // Both requesters held continuously after a fresh reset.
        do_reset(1);
        req0 = 1; a0 = 32'h0FFF_0000; b0 = 32'h000F_FFFF; op0 = 4'd7;
        req1 = 1; a1 = 32'h0FFF_0000; b1 = 32'h000F_FFFF; op1 = 4'd6;
        for (cyc = 0; cyc < 9; cyc++) begin
            step();
            if (gnt0 || gnt1) grant_q.push_back(int'(gnt1));
            if (done0) chk("sub_res0", 64'(result[31:0]), 64'h0FEF_0001);
            if (done1) chk("add_res1", 64'(result[31:0]), 64'h100E_FFFF);
            if (done0 || done1) done_t.push_back(cyc);
        end
        req0 = 0; req1 = 0;
        step(); step();
        chk("grant_cnt", 64'(grant_q.size()), 64'd3);
        if (grant_q.size() >= 3) begin
            chk("grant_1st", 64'(grant_q[0]), 64'd0);
            chk("grant_2nd", 64'(grant_q[1]), 64'd1);
            chk("grant_3rd", 64'(grant_q[2]), 64'd0);
        end
        if (done_t.size() >= 2) chk("done_gap", 64'(done_t[1] - done_t[0]), 64'd3);
        else chk("done_cnt", 64'(done_t.size()), 64'd3);

        // Illegal opcode then a legal NOT_A from requester 1.
        req1 = 1; a1 = 32'h1234_5678; b1 = 32'h1; op1 = 4'b1010;
        step();
        req1 = 0;
        step();
        chk("ill_done1", 64'(done1), 64'h1);
        chk("ill_res", result, 64'h0);
        chk("ill_err", 64'(err), 64'h1);
        step();
        req1 = 1; a1 = 32'h0000_FFFF; op1 = 4'd0;
        step();
        req1 = 0;
        step();
        chk("nota_err", 64'(err), 64'h0);
        chk("nota_res", 64'(result[31:0]), 64'hFFFF_0000);
        step();

        // Operands changed during the grant cycle must be ignored.
        req0 = 1; a0 = 32'd5; b0 = 32'd3; op0 = 4'd6;
        step();
        req0 = 0; a0 = 32'd100; op0 = 4'd7;
        step();
        chk("late_res", result, 64'd8);
        step();

        // Reset during EXEC: no done, prio back to 0.
        req0 = 1; a0 = 32'hFF; b0 = 32'h0F; op0 = 4'd2;
        step(); step(); step();
        step();
        reset = 1; req0 = 0;
        step();
        chk("midrst_done", 64'(done0 | done1), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        reset = 0; req0 = 1; req1 = 1;
        step();
        chk("midrst_gnt0", 64'(gnt0), 64'h1);
        req0 = 0; req1 = 0;
        step(); step();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            req0 = $urandom_range(0, 1); req1 = $urandom_range(0, 1);
            a0 = $urandom; b0 = $urandom; op0 = 4'($urandom_range(0, 15));
            a1 = $urandom; b1 = $urandom; op1 = 4'($urandom_range(0, 15));
            step();
        end
        reset = 0; req0 = 0; req1 = 0;
        step(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
